// File: rtl/tl_ul_initiator.sv
// Single-outstanding TileLink-UL initiator: turns a simple request/response
// client port into 128-bit Get/Put A-channel messages and collects the D reply.
module tl_ul_initiator #(
    parameter logic [2:0]  SOURCE_ID = 3'd0,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wmask,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_rdata,
    output logic         rsp_err,
    output logic         tlmst_a_valid,
    input  logic         tlmst_a_ready,
    output logic [2:0]   tlmst_a_opcode,
    output logic [2:0]   tlmst_a_param,
    output logic [7:0]   tlmst_a_size,
    output logic [2:0]   tlmst_a_source,
    output logic [31:0]  tlmst_a_address,
    output logic [15:0]  tlmst_a_mask,
    output logic [127:0] tlmst_a_data,
    output logic         tlmst_a_corrupt,
    input  logic         tlmst_d_valid,
    output logic         tlmst_d_ready,
    input  logic [2:0]   tlmst_d_opcode,
    input  logic [1:0]   tlmst_d_param,
    input  logic [7:0]   tlmst_d_size,
    input  logic [2:0]   tlmst_d_source,
    input  logic [2:0]   tlmst_d_sink,
    input  logic         tlmst_d_denied,
    input  logic [127:0] tlmst_d_data,
    input  logic         tlmst_d_corrupt
);

    localparam logic [2:0]  OP_PUT_FULL    = 3'd0;
    localparam logic [2:0]  OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0]  OP_GET         = 3'd4;
    localparam logic [2:0]  OP_ACK         = 3'd0;
    localparam logic [2:0]  OP_ACK_DATA    = 3'd1;
    localparam logic        TMO_EN         = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST       = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AREQ  = 3'd1,
        ST_DWAIT = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t         state_r;
    logic           wr_r;
    logic           late_r;
    logic [31:0]    cnt_r;
    logic           req_ready_r;
    logic           rsp_valid_r;
    logic [127:0]   rsp_rdata_r;
    logic           rsp_err_r;
    logic           a_valid_r;
    logic [2:0]     a_opcode_r;
    logic [2:0]     a_param_r;
    logic [7:0]     a_size_r;
    logic [2:0]     a_source_r;
    logic [31:0]    a_address_r;
    logic [15:0]    a_mask_r;
    logic [127:0]   a_data_r;
    logic           a_corrupt_r;
    logic           d_ready_r;

    logic [2:0]     d_exp_op_s;
    logic           d_err_s;
    logic           timeout_hit_s;
    logic           unused_ok_s;

    // Response classification for the beat currently on the D channel.
    always_comb begin
        d_exp_op_s    = wr_r ? OP_ACK : OP_ACK_DATA;
        d_err_s       = tlmst_d_denied | tlmst_d_corrupt |
                        (tlmst_d_source != SOURCE_ID) | (tlmst_d_opcode != d_exp_op_s);
        timeout_hit_s = TMO_EN && (cnt_r == TMO_LAST);
    end

    assign unused_ok_s = ^{tlmst_d_param, tlmst_d_size, tlmst_d_sink, req_addr[3:0]};

    // Transaction FSM; every port-facing signal is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wr_r        <= 1'b0;
            late_r      <= 1'b0;
            cnt_r       <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 128'd0;
            rsp_err_r   <= 1'b0;
            a_valid_r   <= 1'b0;
            a_opcode_r  <= 3'd0;
            a_param_r   <= 3'd0;
            a_size_r    <= 8'd0;
            a_source_r  <= 3'd0;
            a_address_r <= 32'd0;
            a_mask_r    <= 16'd0;
            a_data_r    <= 128'd0;
            a_corrupt_r <= 1'b0;
            d_ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_r        <= req_wr;
                        req_ready_r <= 1'b0;
                        a_valid_r   <= 1'b1;
                        a_opcode_r  <= !req_wr ? OP_GET :
                                       (req_wmask == 16'hFFFF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                        a_param_r   <= 3'd0;
                        a_size_r    <= 8'd4;
                        a_source_r  <= SOURCE_ID;
                        a_address_r <= {req_addr[31:4], 4'h0};
                        a_mask_r    <= req_wr ? req_wmask : 16'hFFFF;
                        a_data_r    <= req_wr ? req_wdata : 128'd0;
                        a_corrupt_r <= 1'b0;
                        state_r     <= ST_AREQ;
                    end
                end
                ST_AREQ: begin
                    if (a_valid_r && tlmst_a_ready) begin
                        a_valid_r <= 1'b0;
                        cnt_r     <= 32'd0;
                        d_ready_r <= 1'b1;
                        state_r   <= ST_DWAIT;
                    end
                end
                ST_DWAIT: begin
                    // A real beat wins over a timeout expiring in the same cycle.
                    if (tlmst_d_valid) begin
                        rsp_rdata_r <= (!wr_r && !d_err_s) ? tlmst_d_data : 128'd0;
                        rsp_err_r   <= d_err_s;
                        rsp_valid_r <= 1'b1;
                        d_ready_r   <= 1'b0;
                        state_r     <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        rsp_rdata_r <= 128'd0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        d_ready_r   <= 1'b0;
                        late_r      <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (late_r) begin
                            d_ready_r <= 1'b1;
                            state_r   <= ST_DRAIN;
                        end else begin
                            req_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Swallow the reply that arrived after we gave up on it.
                    if (tlmst_d_valid) begin
                        late_r      <= 1'b0;
                        d_ready_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    late_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    a_valid_r   <= 1'b0;
                    d_ready_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_r;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_rdata       = rsp_rdata_r;
    assign rsp_err         = rsp_err_r;
    assign tlmst_a_valid   = a_valid_r;
    assign tlmst_a_opcode  = a_opcode_r;
    assign tlmst_a_param   = a_param_r;
    assign tlmst_a_size    = a_size_r;
    assign tlmst_a_source  = a_source_r;
    assign tlmst_a_address = a_address_r;
    assign tlmst_a_mask    = a_mask_r;
    assign tlmst_a_data    = a_data_r;
    assign tlmst_a_corrupt = a_corrupt_r;
    assign tlmst_d_ready   = d_ready_r;

endmodule

// File: tb/tb_tl_ul_initiator.sv
// Directed bench for tl_ul_initiator: the bench plays a small memory responder
// and checks every channel against hand-computed vectors.
module tb_tl_ul_initiator;

    localparam logic [127:0] LINE0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] LINE0P = 128'h00112233_44556677_A5A5A5A5_CCDDEEFF;
    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] DEAD   = {4{32'hDEADBEEF}};
    localparam logic [127:0] JUNK   = {8{16'hBAD0}};

    logic         clk, rst;
    logic         req_valid, req_ready, req_wr;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wmask;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [127:0] rsp_rdata;
    logic         a_valid, a_ready, a_corrupt;
    logic [2:0]   a_opcode, a_param, a_source;
    logic [7:0]   a_size;
    logic [31:0]  a_address;
    logic [15:0]  a_mask;
    logic [127:0] a_data;
    logic         d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]   d_opcode, d_source, d_sink;
    logic [1:0]   d_param;
    logic [7:0]   d_size;
    logic [127:0] d_data;

    int n_cmp = 0;
    int n_bad = 0;
    int a_hs  = 0;
    logic [127:0] mem [16];

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wmask;
        logic         d_denied;
        logic         d_corrupt;
        logic [2:0]   d_src;
        logic [2:0]   d_op;
        logic [2:0]   exp_aop;
        logic [31:0]  exp_aaddr;
        logic [15:0]  exp_amask;
        logic [127:0] exp_adata;
        logic [127:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t vecs [12];

    tl_ul_initiator #(.SOURCE_ID(3'd0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tlmst_a_valid(a_valid), .tlmst_a_ready(a_ready),
        .tlmst_a_opcode(a_opcode), .tlmst_a_param(a_param), .tlmst_a_size(a_size),
        .tlmst_a_source(a_source), .tlmst_a_address(a_address), .tlmst_a_mask(a_mask),
        .tlmst_a_data(a_data), .tlmst_a_corrupt(a_corrupt),
        .tlmst_d_valid(d_valid), .tlmst_d_ready(d_ready),
        .tlmst_d_opcode(d_opcode), .tlmst_d_param(d_param), .tlmst_d_size(d_size),
        .tlmst_d_source(d_source), .tlmst_d_sink(d_sink), .tlmst_d_denied(d_denied),
        .tlmst_d_data(d_data), .tlmst_d_corrupt(d_corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && a_valid && a_ready) a_hs <= a_hs + 1;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [2:0] src,
                           input logic den, input logic cor, input logic [127:0] data);
        d_valid = 1'b1; d_opcode = op; d_source = src; d_denied = den;
        d_corrupt = cor; d_data = data; d_param = 2'd0; d_size = 8'd4; d_sink = 3'd2;
    endtask

    task automatic issue_req(input logic wr, input logic [31:0] addr,
                             input logic [127:0] wdata, input logic [15:0] wmask);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    endtask

    task automatic reset_bundle(input string name);
        chk(name, {req_ready, rsp_valid, rsp_rdata, rsp_err, a_valid, d_ready, a_opcode,
                   a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt},
            {1'b1, 326'd0});
    endtask

    // One complete transaction with zero-latency readies on both sides.
    task automatic do_txn(input vec_t v, input string tag);
        logic [3:0] idx;
        idx = v.addr[7:4];
        @(negedge clk);
        chk({tag, ".req_ready"}, req_ready, 1'b1);
        issue_req(v.wr, v.addr, v.wdata, v.wmask);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".a_valid"}, a_valid, 1'b1);
        chk({tag, ".a_opcode"}, a_opcode, v.exp_aop);
        chk({tag, ".a_address"}, a_address, v.exp_aaddr);
        chk({tag, ".a_mask"}, a_mask, v.exp_amask);
        chk({tag, ".a_data"}, a_data, v.exp_adata);
        chk({tag, ".a_misc"}, {a_param, a_size, a_source, a_corrupt}, {3'd0, 8'd4, 3'd0, 1'b0});
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        chk({tag, ".a_done"}, {a_valid, d_ready}, {1'b0, 1'b1});
        if (v.wr && !v.d_denied) begin
            for (int b = 0; b < 16; b++)
                if (v.wmask[b]) mem[idx][8*b +: 8] = v.wdata[8*b +: 8];
        end
        drive_d(v.d_op, v.d_src, v.d_denied, v.d_corrupt, v.wr ? JUNK : mem[idx]);
        @(negedge clk);
        d_valid = 1'b0;
        chk({tag, ".rsp"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, v.exp_err, v.exp_rdata});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".idle"}, {rsp_valid, req_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0;
        req_wdata = 128'd0; req_wmask = 16'd0; rsp_ready = 1'b0; a_ready = 1'b0;
        d_valid = 1'b0; d_opcode = 3'd0; d_param = 2'd0; d_size = 8'd0; d_source = 3'd0;
        d_sink = 3'd0; d_denied = 1'b0; d_data = 128'd0; d_corrupt = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 128'd0;

        //          wr    addr           wdata   wmask     den   cor   src   dop   aop   aaddr          amask     adata   rdata   err
        vecs[0]  = '{1'b1, 32'h8000_0010, LINE0,  16'hFFFF, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h8000_0010, 16'hFFFF, LINE0,  128'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_001C, LINE2,  16'h0000, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, LINE0,  1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0014, PAT_A5, 16'h00F0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 32'h8000_0010, 16'h00F0, PAT_A5, 128'd0, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 128'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, LINE0P, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0010, 128'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, 128'd0, 1'b1};
        vecs[5]  = '{1'b0, 32'h8000_0010, 128'd0, 16'h0000, 1'b0, 1'b0, 3'd5, 3'd1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, 128'd0, 1'b1};
        vecs[6]  = '{1'b0, 32'h8000_0010, 128'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0, 128'd0, 1'b1};
        vecs[7]  = '{1'b1, 32'h8000_0020, LINE2,  16'hFFFF, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 32'h8000_0020, 16'hFFFF, LINE2,  128'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'h8000_002F, 128'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 32'h8000_0020, 16'hFFFF, 128'd0, LINE2,  1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0030, DEAD,   16'hFFFF, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 32'h8000_0030, 16'hFFFF, DEAD,   128'd0, 1'b1};
        vecs[10] = '{1'b0, 32'h8000_0034, 128'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 32'h8000_0030, 16'hFFFF, 128'd0, 128'd0, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0040, 128'h5A, 16'h0001, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 32'h8000_0040, 16'h0001, 128'h5A, 128'd0, 1'b1};

        @(negedge clk);
        reset_bundle("reset_values");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        // Backpressure on A for 7 cycles, early D beat, then rsp held for 5 cycles.
        @(negedge clk);
        issue_req(1'b0, 32'h8000_0018, 128'd0, 16'd0);
        @(negedge clk);
        req_valid = 1'b0;
        begin
            int hs0;
            hs0 = a_hs;
            chk("bp.a_first", {a_valid, a_opcode, a_address, a_mask, a_data},
                {1'b1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0});
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                chk("bp.a_stable", {a_valid, a_opcode, a_address, a_mask, a_data},
                    {1'b1, 3'd4, 32'h8000_0010, 16'hFFFF, 128'd0});
            end
            a_ready = 1'b1;
            drive_d(3'd1, 3'd0, 1'b0, 1'b0, mem[1]);
            @(negedge clk);
            a_ready = 1'b0;
            chk("bp.d_not_early", {rsp_valid, a_valid, d_ready}, {1'b0, 1'b0, 1'b1});
            @(negedge clk);
            d_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                chk("bp.rsp_stable", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, LINE0P});
                @(negedge clk);
            end
            chk("bp.rsp_held", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, LINE0P});
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("bp.one_a_hs", a_hs, hs0 + 1);
            chk("bp.idle", {rsp_valid, req_ready}, {1'b0, 1'b1});
        end

        // Timeout with no D beat, then the late reply is drained.
        @(negedge clk);
        issue_req(1'b0, 32'h8000_0010, 128'd0, 16'd0);
        @(negedge clk);
        req_valid = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        chk("tmo.dwait", {d_ready, rsp_valid}, {1'b1, 1'b0});
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo.wait%0d", k), rsp_valid, 1'b0);
        end
        @(negedge clk);
        chk("tmo.rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 128'd0});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("tmo.drain", {req_ready, d_ready, rsp_valid}, {1'b0, 1'b1, 1'b0});
        drive_d(3'd1, 3'd0, 1'b0, 1'b0, mem[1]);
        @(negedge clk);
        d_valid = 1'b0;
        chk("tmo.drained", {req_ready, d_ready, rsp_valid}, {1'b1, 1'b0, 1'b0});
        @(negedge clk);
        chk("tmo.no_rsp", rsp_valid, 1'b0);
        do_txn(vecs[3], "tmo.next_get");

        // D beat in exactly the 8th DWAIT cycle is a normal response.
        @(negedge clk);
        issue_req(1'b0, 32'h8000_0010, 128'd0, 16'd0);
        @(negedge clk);
        req_valid = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("edge.wait%0d", k), rsp_valid, 1'b0);
        end
        @(negedge clk);
        chk("edge.d_ready8", {d_ready, rsp_valid}, {1'b1, 1'b0});
        drive_d(3'd1, 3'd0, 1'b0, 1'b0, mem[1]);
        @(negedge clk);
        d_valid = 1'b0;
        chk("edge.rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, LINE0P});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("edge.idle", {req_ready, d_ready}, {1'b1, 1'b0});

        // Reset while A is pending: a_valid drops without a clock edge.
        @(negedge clk);
        issue_req(1'b1, 32'h8000_0050, LINE2, 16'hFFFF);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_areq.pre", a_valid, 1'b1);
        #1 rst = 1'b1;
        #1 reset_bundle("rst_areq.async");
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for D: no response afterwards, fresh Get works.
        @(negedge clk);
        issue_req(1'b0, 32'h8000_0010, 128'd0, 16'd0);
        @(negedge clk);
        req_valid = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        chk("rst_dwait.pre", d_ready, 1'b1);
        #1 rst = 1'b1;
        #1 reset_bundle("rst_dwait.async");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_dwait.no_rsp", {rsp_valid, req_ready}, {1'b0, 1'b1});
        end
        do_txn(vecs[3], "rst.fresh_get");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
